// File: rtl/tone_pkg.sv
// Shared types and constants for the tone_synth channel bank.
package tone_pkg;

  localparam int unsigned DUTY_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_e;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifted right; output bit is lfsr[0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One oscillator: phase counter, pulse threshold, note duration and registered output.
// Optional noise source is built only when TONE_NOISE_EN is defined.
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned DUR_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [PERIOD_WIDTH-1:0] thr,
  input  logic [DUR_WIDTH-1:0]    duration,
`ifdef TONE_NOISE_EN
  input  logic                    noise,
`endif
  input  logic                    tick,
  input  logic                    stop,
  output logic                    ch_out,
  output logic                    active,
  output logic                    done
);

  ch_state_e               state_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] thr_q;
  logic [PERIOD_WIDTH-1:0] phase_q;
  logic [DUR_WIDTH-1:0]    remaining_q;
  logic                    ch_out_q;
  logic                    done_q;
  logic                    run;
  logic                    wrap;
  logic                    tone;

  // Periods of 0 or 1 cannot form a waveform: phase parks at 0 and the tone is silent.
  assign run  = period_q >= PERIOD_WIDTH'(2);
  assign wrap = run && (phase_q == period_q - PERIOD_WIDTH'(1));

`ifdef TONE_NOISE_EN
  logic        noise_q;
  logic [15:0] lfsr_q;

  assign tone = run && (noise_q ? lfsr_q[0] : (phase_q < thr_q));
`else
  assign tone = run && (phase_q < thr_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      period_q    <= '0;
      thr_q       <= '0;
      phase_q     <= '0;
      remaining_q <= '0;
      ch_out_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef TONE_NOISE_EN
      noise_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      done_q   <= 1'b0;
      ch_out_q <= (state_q == PLAY) && tone;
      // Write beats stop and beats an expiry tick landing in the same cycle.
      if (load) begin
        state_q     <= PLAY;
        period_q    <= period;
        thr_q       <= thr;
        phase_q     <= '0;
        remaining_q <= duration;
`ifdef TONE_NOISE_EN
        noise_q     <= noise;
        lfsr_q      <= LFSR_SEED;
`endif
      end else if (stop) begin
        state_q <= IDLE;
      end else if (state_q == PLAY) begin
        if (!run || wrap) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_q + PERIOD_WIDTH'(1);
        end
`ifdef TONE_NOISE_EN
        if (noise_q && wrap) begin
          lfsr_q <= lfsr_next(lfsr_q);
        end
`endif
        if (tick && (remaining_q != '0)) begin
          remaining_q <= remaining_q - DUR_WIDTH'(1);
          if (remaining_q == DUR_WIDTH'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign ch_out = ch_out_q;
  assign active = (state_q == PLAY);
  assign done   = done_q;

endmodule

// File: rtl/tone_synth.sv
// Multi-channel programmable tone generator: shared duration prescaler, write decode and mix.
// Define TONE_NOISE_EN to add the wr_noise port and per-channel LFSR noise.
module tone_synth
  import tone_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned DUR_WIDTH    = 12,
  parameter int unsigned DUR_DIV      = 100000
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [PERIOD_WIDTH-1:0]                       wr_period,
  input  logic [DUTY_WIDTH-1:0]                         wr_duty,
  input  logic [DUR_WIDTH-1:0]                          wr_duration,
`ifdef TONE_NOISE_EN
  input  logic                                          wr_noise,
`endif
  input  logic [CHANNELS-1:0]                           stop,
  output logic [CHANNELS-1:0]                           ch_out,
  output logic [$clog2(CHANNELS+1)-1:0]                 mix,
  output logic [CHANNELS-1:0]                           active,
  output logic [CHANNELS-1:0]                           done
);

  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned MIX_W   = $clog2(CHANNELS + 1);
  localparam int unsigned PRESC_W = $clog2(DUR_DIV);
  localparam int unsigned PROD_W  = PERIOD_WIDTH + DUTY_WIDTH;

  logic [PRESC_W-1:0]      presc_q;
  logic                    tick;
  logic                    wr_hit;
  logic [PROD_W-1:0]       prod;
  logic [PERIOD_WIDTH-1:0] thr;

  // Prescaler free-runs from reset and is never re-phased by writes.
  assign tick = (presc_q == PRESC_W'(DUR_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // One shared multiplier: only the addressed channel ever captures thr.
  assign prod   = PROD_W'(wr_period) * PROD_W'(wr_duty);
  assign thr    = PERIOD_WIDTH'(prod >> DUTY_WIDTH);
  assign wr_hit = wr_en && (32'(wr_ch) < CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tone_channel #(
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .DUR_WIDTH    (DUR_WIDTH)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_hit && (wr_ch == CH_W'(i))),
      .period   (wr_period),
      .thr      (thr),
      .duration (wr_duration),
`ifdef TONE_NOISE_EN
      .noise    (wr_noise),
`endif
      .tick     (tick),
      .stop     (stop[i]),
      .ch_out   (ch_out[i]),
      .active   (active[i]),
      .done     (done[i])
    );
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mix = mix + MIX_W'(ch_out[i]);
    end
  end

endmodule
